// File: rtl/bcd_down_ctr.sv
// rtl/bcd_down_ctr.sv - multi-digit BCD countdown timer with expiry pulse
// Optional periodic reload enabled by defining BCD_DOWN_CTR_AUTO_RELOAD_EN.
module bcd_down_ctr #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  output logic [4*DIGITS-1:0] q,
  output logic                zero,
  output logic                done,
  output logic                busy
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, COUNT, EXPIRE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   q_r, q_nxt, san, dec;
  logic           done_r, busy_r, done_nxt, busy_nxt;
  logic           reload_ok;
  logic [W-1:0]   reload_val;

  // Clamp any non-BCD digit of the start value to 9
  always_comb begin
    san = '0;
    for (int i = 0; i < DIGITS; i++) begin
      san[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_comb begin : decrement
    logic borrow;
    dec    = q_r;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (q_r[4*i +: 4] == 4'd0) begin
          dec[4*i +: 4] = 4'd9;
        end else begin
          dec[4*i +: 4] = q_r[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
  end

`ifdef BCD_DOWN_CTR_AUTO_RELOAD_EN
  logic [W-1:0] reload_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_r <= '0;
    end else if (load) begin
      reload_r <= san;
    end
  end

  assign reload_ok  = |reload_r;
  assign reload_val = reload_r;
`else
  assign reload_ok  = 1'b0;
  assign reload_val = '0;
`endif

  // State register (also holds the registered datapath and flags)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      q_r    <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      q_r    <= q_nxt;
      done_r <= done_nxt;
      busy_r <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (load) begin
      state_nxt = (|san) ? COUNT : IDLE;
    end else begin
      case (state)
        COUNT:   if (en && q_r == W'(1)) state_nxt = EXPIRE;
        IDLE,
        EXPIRE:  state_nxt = (en && reload_ok) ? COUNT : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    q_nxt    = q_r;
    done_nxt = (state_nxt == EXPIRE);
    busy_nxt = (state_nxt == COUNT);
    if (load) begin
      q_nxt = san;
    end else if (en) begin
      if (state == COUNT) begin
        q_nxt = dec;
      end else if (reload_ok) begin
        q_nxt = reload_val;
      end
    end
  end

  assign q    = q_r;
  assign zero = (q_r == '0);
  assign done = done_r;
  assign busy = busy_r;

endmodule
